// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: single-port memory bus between the arbiter (master) and the RAM (slave)
// ram_req_o/ram_we_o/ram_sel_o/ram_addr_o/ram_wdata_o: request fields driven by the master
// ram_rdata_i/ram_ack_i: read data and acknowledge driven by the slave
interface mem_bus_arbiter_if;
   logic        ram_req_o;
   logic        ram_we_o;
   logic [3:0]  ram_sel_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i;
   logic        ram_ack_i;
   modport master(output ram_req_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o, input ram_rdata_i, ram_ack_i);
   modport slave(input ram_req_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o, output ram_rdata_i, ram_ack_i);
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one multi-cycle memory bus between the fetch port and the data port
// clk/rst: clock, synchronous active-high reset
// flush_i/pipe_hold_i: pipeline flush and external hold
// i_*: fetch request and held result; d_*: data request and held result
// stallreq_o: stall to ctrl; bus_err_o: one-cycle pulse on ack timeout; bus: RAM bus master side
module mem_bus_arbiter #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        pipe_hold_i,
   input  logic        i_ce_i,
   input  logic [31:0] i_addr_i,
   output logic [31:0] i_data_o,
   output logic        i_done_o,
   input  logic        d_ce_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_sel_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic [31:0] d_rdata_o,
   output logic        d_done_o,
   output logic        stallreq_o,
   output logic        bus_err_o,
   mem_bus_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, DATA, INST} state_t;
   state_t state, state_n;
   logic req_n, we_n, drop, drop_n, i_done_n, d_done_n, err_n;
   logic busy, ack, tmo, keep, clr;
   logic [3:0] sel_n;
   logic [31:0] addr_n, wdata_n, cnt, cnt_n, i_data_n, d_rdata_n;
   assign stallreq_o = (d_ce_i & ~d_done_o) | (i_ce_i & ~i_done_o);
   always_comb begin
      busy = state != IDLE;
      ack = busy & bus.ram_ack_i;
      tmo = busy & ~bus.ram_ack_i & (ACK_TIMEOUT != 0) & (cnt == ACK_TIMEOUT - 1);
      // a flush on the completing edge discards the result just like an earlier one
      keep = ~(drop | flush_i);
      clr = flush_i | (~stallreq_o & ~pipe_hold_i);
      state_n = state;
      req_n = bus.ram_req_o;
      we_n = bus.ram_we_o;
      sel_n = bus.ram_sel_o;
      addr_n = bus.ram_addr_o;
      wdata_n = bus.ram_wdata_o;
      cnt_n = busy ? cnt + 32'd1 : 32'd0;
      drop_n = busy & (drop | flush_i);
      err_n = tmo;
      i_done_n = i_done_o & ~clr;
      d_done_n = d_done_o & ~clr;
      i_data_n = i_data_o;
      d_rdata_n = d_rdata_o;
      if (ack | tmo) begin
         state_n = IDLE;
         req_n = 1'b0;
         cnt_n = 32'd0;
         drop_n = 1'b0;
         if (keep && state == DATA) begin
            d_done_n = 1'b1;
            d_rdata_n = ack ? bus.ram_rdata_i : 32'd0;
         end
         if (keep && state == INST) begin
            i_done_n = 1'b1;
            i_data_n = ack ? bus.ram_rdata_i : 32'd0;
         end
      end else if (!busy && !flush_i && d_ce_i && !d_done_o) begin
         state_n = DATA;
         req_n = 1'b1;
         we_n = d_we_i;
         sel_n = d_sel_i;
         addr_n = d_addr_i;
         wdata_n = d_wdata_i;
      end else if (!busy && !flush_i && i_ce_i && !i_done_o) begin
         state_n = INST;
         req_n = 1'b1;
         we_n = 1'b0;
         sel_n = 4'b1111;
         addr_n = i_addr_i;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bus.ram_req_o <= 1'b0;
         bus.ram_we_o <= 1'b0;
         bus.ram_sel_o <= 4'd0;
         bus.ram_addr_o <= 32'd0;
         bus.ram_wdata_o <= 32'd0;
         cnt <= 32'd0;
         drop <= 1'b0;
         bus_err_o <= 1'b0;
         i_done_o <= 1'b0;
         d_done_o <= 1'b0;
         i_data_o <= 32'd0;
         d_rdata_o <= 32'd0;
      end else begin
         state <= state_n;
         bus.ram_req_o <= req_n;
         bus.ram_we_o <= we_n;
         bus.ram_sel_o <= sel_n;
         bus.ram_addr_o <= addr_n;
         bus.ram_wdata_o <= wdata_n;
         cnt <= cnt_n;
         drop <= drop_n;
         bus_err_o <= err_n;
         i_done_o <= i_done_n;
         d_done_o <= d_done_n;
         i_data_o <= i_data_n;
         d_rdata_o <= d_rdata_n;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
   typedef struct {logic we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata; bit chk_w;} bus_t;
   typedef struct {bit is_d; logic [31:0] v;} res_t;
   logic clk, rst, flush, hold;
   logic i_ce, i_done, d_ce, d_we, d_done, stall, err;
   logic [3:0] d_sel;
   logic [31:0] i_addr, i_data, d_addr, d_wdata, d_rdata;
   logic t_ce, t_done, t_stall, t_err, t_i_done;
   logic [31:0] t_rdata, t_i_data;
   int tests = 0, fails = 0, stall_hi = 0, req_hi = 0;
   bus_t exp_bus[$];
   res_t exp_res[$];
   mem_bus_arbiter_if bus();
   mem_bus_arbiter_if t_bus();
   mem_bus_arbiter dut (
      .clk(clk), .rst(rst), .flush_i(flush), .pipe_hold_i(hold),
      .i_ce_i(i_ce), .i_addr_i(i_addr), .i_data_o(i_data), .i_done_o(i_done),
      .d_ce_i(d_ce), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_rdata_o(d_rdata), .d_done_o(d_done), .stallreq_o(stall), .bus_err_o(err), .bus(bus)
   );
   mem_bus_arbiter #(.ACK_TIMEOUT(4)) dut_t (
      .clk(clk), .rst(rst), .flush_i(1'b0), .pipe_hold_i(1'b0),
      .i_ce_i(1'b0), .i_addr_i(32'd0), .i_data_o(t_i_data), .i_done_o(t_i_done),
      .d_ce_i(t_ce), .d_we_i(1'b0), .d_sel_i(4'hF), .d_addr_i(32'h300), .d_wdata_i(32'd0),
      .d_rdata_o(t_rdata), .d_done_o(t_done), .stallreq_o(t_stall), .bus_err_o(t_err), .bus(t_bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      stall_hi <= stall_hi + (stall ? 1 : 0);
      req_hi <= req_hi + (bus.ram_req_o ? 1 : 0);
   end
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic serve(int hi, logic [31:0] rd);
      bus_t e;
      int n = 0;
      while (!bus.ram_req_o && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", bus.ram_req_o, 1);
      if (exp_bus.size() > 0) begin
         e = exp_bus.pop_front();
         chk("bus_we", bus.ram_we_o, e.we);
         chk("bus_sel", bus.ram_sel_o, e.sel);
         chk("bus_addr", bus.ram_addr_o, e.addr);
         if (e.chk_w) chk("bus_wdata", bus.ram_wdata_o, e.wdata);
      end
      for (int i = 1; i < hi; i++) tick();
      bus.ram_ack_i = 1'b1;
      bus.ram_rdata_i = rd;
      tick();
      bus.ram_ack_i = 1'b0;
      bus.ram_rdata_i = 32'hDEADBEEF;
   endtask
   task automatic res_chk();
      res_t r;
      chk("res_avail", exp_res.size(), 1);
      if (exp_res.size() > 0) begin
         r = exp_res.pop_front();
         chk(r.is_d ? "d_rdata" : "i_data", r.is_d ? d_rdata : i_data, r.v);
      end
   endtask
   initial begin
      int s0, r0, n;
      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      i_ce = 1'b0; i_addr = 32'd0; d_ce = 1'b0; d_we = 1'b0; d_sel = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
      t_ce = 1'b0;
      bus.ram_ack_i = 1'b0; bus.ram_rdata_i = 32'd0;
      t_bus.ram_ack_i = 1'b0; t_bus.ram_rdata_i = 32'hA5A5A5A5;
      tick(); tick();
      chk("rst_req", bus.ram_req_o, 0);
      chk("rst_done", {i_done, d_done}, 0);
      chk("rst_data", i_data | d_rdata, 0);
      chk("rst_err_stall", {err, stall}, 0);
      rst = 1'b0;
      tick();
      // data read, slave acks after two request cycles
      s0 = stall_hi; r0 = req_hi;
      d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h40;
      exp_bus.push_back('{1'b0, 4'hF, 32'h40, 32'd0, 1'b0});
      exp_res.push_back('{1'b1, 32'h12345678});
      serve(2, 32'h12345678);
      chk("t1_d_done", d_done, 1);
      res_chk();
      chk("t1_stall_now", stall, 0);
      chk("t1_req_now", bus.ram_req_o, 0);
      chk("t1_stall_cycles", stall_hi - s0, 3);
      chk("t1_req_cycles", req_hi - r0, 2);
      d_ce = 1'b0;
      tick();
      chk("t1_done_clr", d_done, 0);
      // data write plus fetch in the same pipeline cycle, zero-wait slave
      s0 = stall_hi;
      d_ce = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h100; d_wdata = 32'hAABBCCDD;
      i_ce = 1'b1; i_addr = 32'h400;
      exp_bus.push_back('{1'b1, 4'b0011, 32'h100, 32'hAABBCCDD, 1'b1});
      exp_bus.push_back('{1'b0, 4'hF, 32'h400, 32'd0, 1'b0});
      serve(1, 32'hDEAD0001);
      chk("t2_d_done", d_done, 1);
      chk("t2_stall_mid", stall, 1);
      exp_res.push_back('{1'b0, 32'h0BADF00D});
      serve(1, 32'h0BADF00D);
      chk("t2_both_done", {d_done, i_done}, 2'b11);
      res_chk();
      chk("t2_stall_now", stall, 0);
      chk("t2_stall_cycles", stall_hi - s0, 4);
      d_ce = 1'b0; i_ce = 1'b0;
      tick();
      chk("t2_done_clr", {d_done, i_done}, 0);
      // fetch completes while the pipeline is held elsewhere
      hold = 1'b1; i_ce = 1'b1; i_addr = 32'h800;
      exp_bus.push_back('{1'b0, 4'hF, 32'h800, 32'd0, 1'b0});
      exp_res.push_back('{1'b0, 32'hCAFEBABE});
      serve(1, 32'hCAFEBABE);
      r0 = req_hi;
      for (int i = 0; i < 3; i++) tick();
      chk("t3_no_reissue", req_hi - r0, 0);
      chk("t3_i_done_held", i_done, 1);
      res_chk();
      hold = 1'b0;
      tick();
      chk("t3_done_clr", i_done, 0);
      i_ce = 1'b0;
      chk("t3_data_kept", i_data, 32'hCAFEBABE);
      tick();
      chk("t3_req_idle", bus.ram_req_o, 0);
      // flush one cycle into a data read; the bus transaction still finishes
      r0 = req_hi;
      d_ce = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h200;
      exp_bus.push_back('{1'b0, 4'hF, 32'h200, 32'd0, 1'b0});
      tick();
      chk("t4_req", bus.ram_req_o, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0; d_ce = 1'b0;
      tick();
      tick();
      chk("t4_req_held", bus.ram_req_o, 1);
      bus.ram_ack_i = 1'b1; bus.ram_rdata_i = 32'h55555555;
      tick();
      bus.ram_ack_i = 1'b0;
      chk("t4_req_cycles", req_hi - r0, 4);
      chk("t4_req_off", bus.ram_req_o, 0);
      chk("t4_no_done", d_done, 0);
      chk("t4_rdata_kept", d_rdata, 32'hDEAD0001);
      void'(exp_bus.pop_front());
      // timeout with ACK_TIMEOUT=4 and a silent slave
      t_ce = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (t_done) break;
         if (t_bus.ram_req_o) n++;
      end
      chk("t5_req_cycles", n, 4);
      chk("t5_done", t_done, 1);
      chk("t5_err", t_err, 1);
      chk("t5_rdata", t_rdata, 0);
      chk("t5_req_off", t_bus.ram_req_o, 0);
      t_ce = 1'b0;
      tick();
      chk("t5_err_pulse", t_err, 0);
      // reset in the middle of a fetch; a late ack is ignored
      i_ce = 1'b1; i_addr = 32'h900;
      tick();
      chk("t6_req", bus.ram_req_o, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; i_ce = 1'b0;
      chk("t6_req_rst", bus.ram_req_o, 0);
      chk("t6_outs_rst", {i_done, d_done, err}, 0);
      chk("t6_data_rst", i_data | d_rdata, 0);
      bus.ram_ack_i = 1'b1; bus.ram_rdata_i = 32'h77777777;
      tick();
      bus.ram_ack_i = 1'b0;
      tick();
      chk("t6_ack_ignored", {i_done, d_done, err, bus.ram_req_o}, 0);
      chk("t6_data_ignored", i_data, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
